// File: rtl/rv32i_types.sv
// Shared types for the reorder buffer.
//   rob_entry_t   : one buffer entry {valid, ready, rd_addr, rd_data, pc}
//   ex_data_bus_t : one execution-unit result bus {ready, rob_id, rd_data}
package rv32i_types;

  localparam int ROB_ID_SIZE = 4;
  localparam int EX_UNITS    = 4;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pc;
  } rob_entry_t;

  typedef struct packed {
    logic                   ready;
    logic [ROB_ID_SIZE-1:0] rob_id;
    logic [31:0]            rd_data;
  } ex_data_bus_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order completion buffer.
//   clk, rst              : clock, synchronous active-high reset
//   branch_mispredict     : flush every entry at this edge
//   alloc_valid/rd/pc     : dispatch allocation request
//   rob_id_dest, full     : id handed to dispatch (current tail), stall flag
//   ex_bus                : result buses snooped for writeback
//   rob_data_bus          : register view of every entry
//   commit_*              : head retirement outputs (combinational)
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int ROB_ID_SIZE = rv32i_types::ROB_ID_SIZE,
  parameter int EX_UNITS    = rv32i_types::EX_UNITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                branch_mispredict,
  input  logic                                alloc_valid,
  input  logic [4:0]                          alloc_rd,
  input  logic [31:0]                         alloc_pc,
  output logic [ROB_ID_SIZE-1:0]              rob_id_dest,
  output logic                                full,
  input  ex_data_bus_t [EX_UNITS-1:0]         ex_bus,
  output rob_entry_t [2**ROB_ID_SIZE-1:0]     rob_data_bus,
  output logic                                commit_valid,
  output logic [4:0]                          commit_rd,
  output logic [31:0]                         commit_data,
  output logic [31:0]                         commit_pc,
  output logic                                commit_we,
  output logic [ROB_ID_SIZE-1:0]              commit_rob_id
);

  localparam int N = 2**ROB_ID_SIZE;
  localparam logic [ROB_ID_SIZE:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ROB_ID_SIZE:0]   head_q, head_d, tail_q, tail_d;
  rob_entry_t [N-1:0]     entries_q, entries_d;
  logic [ROB_ID_SIZE-1:0] head_idx, tail_idx;

  assign head_idx = head_q[ROB_ID_SIZE-1:0];
  assign tail_idx = tail_q[ROB_ID_SIZE-1:0];

  // Registered pointers only: a commit in this cycle does not free a slot
  // for an allocation in this cycle.
  assign full = (head_q[ROB_ID_SIZE] != tail_q[ROB_ID_SIZE]) && (head_idx == tail_idx);

  assign rob_id_dest   = tail_idx;
  assign rob_data_bus  = entries_q;

  assign commit_valid  = entries_q[head_idx].valid && entries_q[head_idx].ready;
  assign commit_rd     = entries_q[head_idx].rd_addr;
  assign commit_data   = entries_q[head_idx].rd_data;
  assign commit_pc     = entries_q[head_idx].pc;
  assign commit_we     = commit_valid && (entries_q[head_idx].rd_addr != 5'd0);
  assign commit_rob_id = head_idx;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;

    // Writeback first, so a commit in the same cycle still clears its entry.
    // Ascending order lets the higher-numbered bus win on a collision.
    for (int k = 0; k < EX_UNITS; k++) begin
      if (ex_bus[k].ready && entries_q[ex_bus[k].rob_id].valid) begin
        entries_d[ex_bus[k].rob_id].ready   = 1'b1;
        entries_d[ex_bus[k].rob_id].rd_data = ex_bus[k].rd_data;
      end
    end

    if (commit_valid) begin
      entries_d[head_idx].valid = 1'b0;
      entries_d[head_idx].ready = 1'b0;
      head_d = head_q + PTR_ONE;
    end

    if (alloc_valid && !full) begin
      entries_d[tail_idx].valid   = 1'b1;
      entries_d[tail_idx].ready   = 1'b0;
      entries_d[tail_idx].rd_addr = alloc_rd;
      entries_d[tail_idx].pc      = alloc_pc;
      tail_d = tail_q + PTR_ONE;
    end

    // The commit above is still reported this cycle; everything else is dropped.
    if (branch_mispredict) begin
      head_d = '0;
      tail_d = '0;
      for (int i = 0; i < N; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].ready = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      entries_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

  // Two results for the same live entry in one cycle cannot happen legally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < EX_UNITS; j++) begin
        for (int k = j + 1; k < EX_UNITS; k++) begin
          assert (!(ex_bus[j].ready && ex_bus[k].ready &&
                    (ex_bus[j].rob_id == ex_bus[k].rob_id) &&
                    entries_q[ex_bus[j].rob_id].valid))
            else $error("two result buses target rob_id %0d", ex_bus[j].rob_id);
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import rv32i_types::*;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, branch_mispredict, alloc_valid;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic [3:0]  rob_id_dest;
  logic        full;
  ex_data_bus_t [3:0] ex_bus;
  rob_entry_t [15:0]  rob_data_bus;
  logic        commit_valid, commit_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, commit_pc;
  logic [3:0]  commit_rob_id;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  logic [31:0] planned [16];
  int m_tail = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .rob_id_dest(rob_id_dest), .full(full), .ex_bus(ex_bus),
    .rob_data_bus(rob_data_bus), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_pc(commit_pc),
    .commit_we(commit_we), .commit_rob_id(commit_rob_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every visible commit must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit_unexpected actual=id%0d required=none at %0t", commit_rob_id, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_rob_id", 64'(commit_rob_id), 64'(e.id));
        chk("commit_rd",     64'(commit_rd),     64'(e.rd));
        chk("commit_data",   64'(commit_data),   64'(e.data));
        chk("commit_pc",     64'(commit_pc),     64'(e.pc));
        chk("commit_we",     64'(commit_we),     64'(e.rd != 5'd0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; branch_mispredict = 1'b0; alloc_valid = 1'b0;
    alloc_rd = '0; alloc_pc = '0; ex_bus = '0;
    tick(); tick();
    rst = 1'b0;
    m_tail = 0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] data, input bit push);
    exp_t e;
    chk("alloc_id", 64'(rob_id_dest), 64'(m_tail % 16));
    alloc_valid = 1'b1; alloc_rd = rd; alloc_pc = pc;
    planned[m_tail % 16] = data;
    e.id = 4'(m_tail % 16); e.rd = rd; e.data = data; e.pc = pc;
    if (push) exp_q.push_back(e);
    tick();
    alloc_valid = 1'b0;
    m_tail++;
  endtask

  task automatic wb(input int k, input int id);
    ex_bus = '0;
    ex_bus[k].ready   = 1'b1;
    ex_bus[k].rob_id  = 4'(id);
    ex_bus[k].rd_data = planned[id];
    tick();
    ex_bus = '0;
  endtask

  initial begin
    logic any_valid;
    logic [3:0] occ;

    // Reset state and in-order commit of out-of-order results
    do_reset();
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_id", 64'(rob_id_dest), 64'd0);
    chk("rst_entry_valid", 64'(rob_data_bus[0].valid), 64'd0);
    alloc(5'd1, 32'h100, 32'h10, 1);
    alloc(5'd2, 32'h104, 32'h20, 1);
    alloc(5'd3, 32'h108, 32'h30, 1);
    chk("three_full", 64'(full), 64'd0);
    chk("no_commit_early", 64'(commit_valid), 64'd0);
    wb(0, 2);
    chk("no_commit_id2_only", 64'(commit_valid), 64'd0);
    chk("id2_ready", 64'(rob_data_bus[2].ready), 64'd1);
    wb(1, 0);
    chk("commit_after_id0", 64'(commit_valid), 64'd1);
    wb(2, 1);
    tick(); tick(); tick();
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Fill all 16 entries, refuse allocation while full, wrap the tail
    do_reset();
    for (int i = 0; i < 16; i++)
      alloc(5'(i + 4), 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_id_wrap", 64'(rob_id_dest), 64'd0);
    alloc_valid = 1'b1; alloc_rd = 5'd7; alloc_pc = 32'hdead;
    tick();
    chk("refuse_full", 64'(full), 64'd1);
    chk("refuse_pc", 64'(rob_data_bus[0].pc), 64'h200);
    ex_bus = '0;
    ex_bus[1].ready = 1'b1; ex_bus[1].rob_id = 4'd0; ex_bus[1].rd_data = planned[0];
    tick();
    ex_bus = '0;
    chk("full_commit_visible", 64'(commit_valid), 64'd1);
    chk("full_no_lookahead", 64'(full), 64'd1);
    tick();
    alloc_valid = 1'b0;
    chk("full_cleared", 64'(full), 64'd0);
    chk("refused_pc_still", 64'(rob_data_bus[0].valid), 64'd0);
    chk("wrap_id", 64'(rob_id_dest), 64'd0);
    alloc(5'd0, 32'h300, 32'h55, 1);
    chk("wrap_entry_valid", 64'(rob_data_bus[0].valid), 64'd1);
    chk("wrap_full_again", 64'(full), 64'd1);
    for (int i = 1; i < 16; i++) wb(i % 4, i);
    wb(3, 0);
    tick(); tick(); tick();
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Flush with the head ready, alloc and writeback in the same cycle
    do_reset();
    alloc(5'd5, 32'h500, 32'hA0, 1);
    for (int i = 1; i < 5; i++) alloc(5'(5 + i), 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 0);
    wb(0, 0);
    branch_mispredict = 1'b1;
    alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_pc = 32'h999;
    ex_bus[2].ready = 1'b1; ex_bus[2].rob_id = 4'd1; ex_bus[2].rd_data = 32'hbad;
    chk("flush_head_commits", 64'(commit_valid), 64'd1);
    tick();
    branch_mispredict = 1'b0; alloc_valid = 1'b0; ex_bus = '0;
    m_tail = 0;
    any_valid = 1'b0;
    for (int i = 0; i < 16; i++) any_valid = any_valid | rob_data_bus[i].valid;
    chk("flush_all_invalid", 64'(any_valid), 64'd0);
    chk("flush_id", 64'(rob_id_dest), 64'd0);
    chk("flush_full", 64'(full), 64'd0);
    chk("flush_commit", 64'(commit_valid), 64'd0);
    chk("flush_wb_dropped", 64'(rob_data_bus[1].ready), 64'd0);
    chk("flush_drained", 64'(exp_q.size()), 64'd0);

    // Writeback to an unallocated id, then steady alloc+commit
    alloc(5'd1, 32'h600, 32'hB0, 1);
    alloc(5'd2, 32'h604, 32'hB1, 1);
    ex_bus[3].ready = 1'b1; ex_bus[3].rob_id = 4'd9; ex_bus[3].rd_data = 32'hffff;
    tick();
    ex_bus = '0;
    chk("unalloc_ready", 64'(rob_data_bus[9].ready), 64'd0);
    chk("unalloc_valid", 64'(rob_data_bus[9].valid), 64'd0);
    wb(0, 0);
    for (int i = 0; i < 20; i++) begin
      ex_bus = '0;
      ex_bus[i % 4].ready   = 1'b1;
      ex_bus[i % 4].rob_id  = 4'((m_tail - 1) % 16);
      ex_bus[i % 4].rd_data = planned[(m_tail - 1) % 16];
      alloc(5'((i % 30) + 1), 32'h700 + 32'(4 * i), 32'hC00 + 32'(i), 1);
      ex_bus = '0;
      occ = rob_id_dest - commit_rob_id;
      chk("steady_occupancy", 64'(occ), 64'd2);
    end
    wb(1, (m_tail - 1) % 16);
    tick(); tick(); tick();
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order completion buffer between decode/dispatch and the architectural register file.
- Allocates one entry per dispatched instruction and returns its rob_id to the reservation stations.
- Captures results from every execution-unit data bus and exposes all entries as rob_data_bus, so stations can read operands at dispatch and while waiting.
- Retires the head entry in program order, at most one per cycle, and flushes completely on branch mispredict.

Parameters:
- ROB_ID_SIZE, default 4: log2 of entry count (16 entries); width of rob_id.
- EX_UNITS, default 4: number of execution-unit result buses snooped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- branch_mispredict  in  1  flush all entries at this edge.
- alloc_valid  in  1  dispatch requests one entry this cycle.
- alloc_rd  in  5  destination architectural register.
- alloc_pc  in  32  instruction PC, kept for commit.
- rob_id_dest  out  ROB_ID_SIZE  index that will be allocated (current tail).
- full  out  1  no free entry; dispatch must stall.
- ex_bus  in  ex_data_bus_t[EX_UNITS]  result buses {ready, rob_id, rd_data}.
- rob_data_bus  out  rob_entry_t[2**ROB_ID_SIZE]  per-entry {valid, ready, rd_addr, rd_data, pc}.
- commit_valid  out  1  head entry retires this cycle.
- commit_rd  out  5  register to write.
- commit_data  out  32  value to write.
- commit_pc  out  32  PC of retiring instruction.
- commit_we  out  1  commit_valid && commit_rd != 0.
- commit_rob_id  out  ROB_ID_SIZE  head index; used by rename to clear its tag.

Behaviour:
- State: head_ptr and tail_ptr, each ROB_ID_SIZE+1 bits (MSB is the wrap bit); entry array.
- Empty: ptrs equal. Full: low bits equal and wrap bits differ. The full output is combinational from registered pointers only and never looks ahead to a same-cycle commit.
- Reset or flush (synchronous, at the edge): head=tail=0, every entry valid=0, ready=0.
  - All outputs follow combinationally: full=0, commit_valid=0, commit_we=0, rob_id_dest=0.
  - rd_data/pc contents are don't-care.
  - rst has priority over everything.
- Flush in the same cycle as a visible commit: that commit is still performed (the mispredicting branch retires). Allocation and writeback in the flush cycle are discarded.
- Allocate when alloc_valid && !full:
  - entry[tail] gets valid=1, ready=0, rd_addr=alloc_rd, pc=alloc_pc.
  - tail advances by 1, wrapping 2**ROB_ID_SIZE-1 to 0 with the wrap bit toggled.
  - rob_id_dest = tail low bits in the same cycle, so dispatch and the station latch the same id at the same edge.
  - alloc_valid while full is ignored; no state change.
- Writeback, for each k when ex_bus[k].ready and entry[ex_bus[k].rob_id].valid: set ready=1 and rd_data=ex_bus[k].rd_data.
  - Buses targeting invalid entries are ignored.
  - Two buses to the same id in one cycle is illegal (assertion); the higher k wins.
  - The write is visible on rob_data_bus from the next cycle; there is no same-cycle bypass.
- Commit is combinational: commit_valid = entry[head].valid && entry[head].ready. Outputs are taken from entry[head].
  - At the edge, if commit_valid: entry[head].valid=0, ready=0, and head advances.
  - Latency: result on bus at cycle N, ready at N+1, commit at N+1 if it is the head.
- Same cycle, allocation and commit: both happen, and count is unchanged.
  - When full, the allocation is refused even if a commit occurs that cycle.
  - When empty, a same-cycle allocation cannot commit, because ready=0.
- rob_data_bus[i] is a direct register view of every entry (valid, ready, rd_data, etc.).

Decomposition:
- rv32i_types holds:
  - rob_entry_t {valid, ready, rd_addr[4:0], rd_data[31:0], pc[31:0]};
  - ex_data_bus_t;
  - ROB_ID_SIZE and EX_UNITS constants.
- No sub-module. A single file with pointer logic, entry array, writeback loop and commit comb block.

Test Plan:
- Reset, then dispatch 3 instrs (rd=1,2,3) -> rob_id_dest 0,1,2; full=0; no commit until results arrive.
- Results out of order: id2=0x30 at cycle 5, id0=0x10 at 6, id1=0x20 at 7 -> commits occur in order:
  - rd1=0x10 at 7;
  - rd2=0x20 at 8;
  - rd3=0x30 at 9.
- Fill 16 entries -> full=1 after the 16th; alloc_valid held -> no allocation; commit head -> full=0 next cycle; tail wraps to id 0 with the wrap bit set.
- rd=0 entry completes -> commit_valid=1, commit_we=0.
- Flush with the head ready and 5 entries live, plus alloc and ex_bus in the same cycle:
  - head commits that cycle;
  - next cycle all valid=0, rob_id_dest=0, full=0;
  - discarded writeback has no effect.
- ex_bus to an unallocated id 9 -> rob_data_bus[9].ready stays 0; simultaneous alloc+commit at steady state keeps occupancy constant over 20 cycles.
